// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: single-outstanding command-to-AHB-Lite master.
// Accepts one read/write command and runs a NONSEQ address phase and then
// a data phase. It returns a one-cycle response pulse and can overlap the
// next address phase with the current data phase.
// Optional macro AHB_CMD_MASTER_TIMEOUT_EN adds an abort after
// TIMEOUT_CYCLES+1 consecutive data-phase wait states (rsp_err=1).
module ahb_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  // AHB master side
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [7:0] TO_LIM        = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              rst_done;     // low for the cycle after a reset edge
  logic              hready_ok;    // hready is exactly 1 (X/Z -> wait)
  logic              accept;
  logic              complete;
  logic              timeout_hit;
  logic [DATA_W-1:0] wdata_q;

  // Only a clean 1 ends a phase; an unknown hready falls to the else path.
  always_comb begin
    hready_ok = 1'b0;
    if (hready == 1'b1) hready_ok = 1'b1;
  end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
  logic [7:0] to_cnt;

  assign timeout_hit = (state == ST_DATA) && !hready_ok && (to_cnt == TO_LIM);

  // Count consecutive data-phase wait states; any other cycle clears it.
  always_ff @(posedge hclk) begin
    if (!hresetn)
      to_cnt <= 8'd0;
    else if ((state == ST_DATA) && !hready_ok && !timeout_hit)
      to_cnt <= to_cnt + 8'd1;
    else
      to_cnt <= 8'd0;
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TO_LIM;
`endif

  // The data phase may also take the next command when it completes.
  assign cmd_ready = rst_done &&
                     ((state == ST_IDLE) || ((state == ST_DATA) && hready_ok));
  assign accept    = cmd_valid && cmd_ready;
  assign complete  = (state == ST_DATA) && hready_ok;
  assign busy      = (state != ST_IDLE);

  // Hold cmd_ready low for the first cycle after reset.
  always_ff @(posedge hclk) begin
    if (!hresetn) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  // State register.
  always_ff @(posedge hclk) begin
    if (!hresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: IDLE -> ADDR -> DATA -> (ADDR | IDLE).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_ADDR;
      ST_ADDR: if (hready_ok) state_nxt = ST_DATA;
      ST_DATA: begin
        if (hready_ok)        state_nxt = accept ? ST_ADDR : ST_IDLE;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // AHB bus outputs and the captured write data.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      haddr   <= '0;
      hwrite  <= 1'b0;
      htrans  <= HTRANS_IDLE;
      hwdata  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      // A new address phase, which can overlap a completing data phase.
      haddr   <= cmd_addr;
      hwrite  <= cmd_write;
      htrans  <= HTRANS_NONSEQ;
      wdata_q <= cmd_wdata;
    end else if ((state == ST_ADDR) && hready_ok) begin
      // Enter the data phase. Reads leave hwdata at its last value.
      htrans <= HTRANS_IDLE;
      if (hwrite) hwdata <= wdata_q;
    end else if (complete || timeout_hit) begin
      // Return to idle. haddr keeps its last value.
      hwrite <= 1'b0;
      htrans <= HTRANS_IDLE;
    end
  end

  // Response pulse, one cycle after the data phase ends or aborts.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= complete || timeout_hit;
      rsp_err   <= timeout_hit;
      if (complete || timeout_hit) begin
        rsp_write <= hwrite;
        rsp_rdata <= (complete && !hwrite) ? hrdata : '0;
      end
    end
  end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 Parameter ADDR_W, default 32, width of haddr and cmd_addr.
REQ-002 Parameter DATA_W, default 32, width of hwdata, hrdata, cmd_wdata and rsp_rdata.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, limit on consecutive wait-state cycles in one data phase; legal range 1..255.
REQ-004 Clocking and reset SHALL be one clock, hclk; reset hresetn is synchronous and active-low.
REQ-005 hclk  input  1  bus clock; all state changes on its rising edge.
REQ-006 hresetn  input  1  synchronous active-low reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge of hclk.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_addr  input  ADDR_W  transfer address.
REQ-011 cmd_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-013 rsp_write  output  1  direction of the completed transfer.
REQ-014 rsp_rdata  output  DATA_W  read data; 0 for writes and for errors.
REQ-015 rsp_err  output  1  transfer aborted by timeout.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 haddr  output  ADDR_W  AHB address.
REQ-018 hwrite  output  1  AHB direction.
REQ-019 htrans  output  2  AHB transfer type: 2'b00 IDLE, 2'b10 NONSEQ; other encodings never driven.
REQ-020 hwdata  output  DATA_W  AHB write data.
REQ-021 hrdata  input  DATA_W  AHB read data.
REQ-022 hready  input  1  AHB ready; only the value 1 completes a phase, so X or Z counts as a wait state.

Function
REQ-023 The block SHALL implement states IDLE, ADDR and DATA.
REQ-024 cmd_ready SHALL be high in IDLE, and high in DATA only in a cycle where hready==1; it SHALL be low otherwise.
REQ-025 Command accept SHALL move the block to ADDR next cycle, driving haddr=cmd_addr, hwrite=cmd_write, htrans=2'b10, and capturing cmd_wdata.
REQ-026 ADDR SHALL hold all address-phase outputs until a rising edge with hready==1, then move to DATA.
REQ-027 On entering DATA the block SHALL drive htrans=2'b00, and SHALL drive hwdata with the captured data for writes and hold hwdata at its last value for reads.
REQ-028 In DATA, a rising edge with hready==1 SHALL complete the transfer, and rsp_valid SHALL pulse high for exactly one cycle in the following cycle.
REQ-029 On that completion pulse, rsp_write SHALL equal the transfer direction, and rsp_rdata SHALL equal hrdata sampled at that edge for reads and 0 for writes.
REQ-030 Back-to-back accept: a command accepted on the completing edge of DATA SHALL put the block in ADDR the next cycle, giving one transfer per 2 cycles with zero wait states.
REQ-031 Completion with no new command SHALL return the block to IDLE.
REQ-032 Read latency SHALL be accept edge to rsp_valid of 3 cycles with zero wait states, plus 1 cycle per wait state.
REQ-033 In IDLE the block SHALL drive htrans=2'b00 and hwrite=0, and haddr SHALL hold its last value.
REQ-034 A cmd_valid arriving while cmd_ready is low SHALL not be accepted, and command inputs SHALL be ignored until accepted.

Reset
REQ-035 A rising edge with hresetn==0 SHALL set state=IDLE, cmd_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, busy=0, haddr=0, hwrite=0, htrans=2'b00, hwdata=0 and the timeout counter to 0.
REQ-036 cmd_ready SHALL rise in the first cycle after reset is released.
REQ-037 Reset asserted mid-transfer, in ADDR or DATA, SHALL abandon the transfer with no rsp_valid pulse.

Configuration
REQ-038 With macro AHB_CMD_MASTER_TIMEOUT_EN defined, an 8-bit counter SHALL count consecutive DATA cycles with hready!=1 and SHALL clear on phase completion.
REQ-039 With AHB_CMD_MASTER_TIMEOUT_EN defined, a counter value equal to TIMEOUT_CYCLES at a waiting edge SHALL abort the transfer: rsp_valid=1, rsp_err=1 and rsp_rdata=0 next cycle, state IDLE, and no command accepted on that edge.
REQ-040 With AHB_CMD_MASTER_TIMEOUT_EN undefined, the counter SHALL be absent, DATA SHALL wait indefinitely, and rsp_err SHALL be tied to 0.

Verification
REQ-041 Scenario: write 0x0000_0010 <- 0xDEAD_BEEF then read 0x10, zero wait states -> htrans 2'b10 in each address phase, hwdata=0xDEADBEEF, rsp_rdata=0xDEADBEEF, read latency 3 cycles.
REQ-042 Scenario: four reads with cmd_valid held high -> htrans=2'b10 every 2nd cycle and four rsp_valid pulses 2 cycles apart.
REQ-043 Scenario: read with hready=0 for 3 data-phase cycles -> cmd_ready low during the wait, rsp_valid 6 cycles after accept.
REQ-044 Scenario: hresetn=0 for one cycle during the DATA phase of a write -> no rsp_valid, all outputs at reset values, cmd_ready=1 one cycle after release.
REQ-045 Scenario: macro defined, TIMEOUT_CYCLES=4, hready held 0 in data phase -> rsp_err=1, rsp_rdata=0, return to IDLE; macro undefined -> no response until hready=1.
